// File: rtl/shift_engine.sv
// Iterative shift/rotate engine: a request is accepted, applied STEP bits per cycle,
// and the result is held until the consumer takes it.
`timescale 1ns/1ps

module shift_engine #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned STEP  = 1,
  localparam int unsigned AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AW-1:0]    in_amount,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    M_ROR  = 3'd0,
    M_ROL  = 3'd1,
    M_SHR  = 3'd2,
    M_SHL  = 3'd3,
    M_SHRA = 3'd4
  } mode_t;

  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AW-1:0]    remaining_q, remaining_d;
  logic [2:0]       mode_q, mode_d;

  logic [AW-1:0]    k;
  logic [AW-1:0]    k_inv;
  logic [AW-1:0]    accept_amount;
  logic [WIDTH-1:0] step_result;

  // k_inv wraps to WIDTH-k; for k=0 both rotate halves equal work, so the
  // rotate result is still the identity.
  always_comb begin
    k     = (remaining_q < STEP_A) ? remaining_q : STEP_A;
    k_inv = '0 - k;
  end

  always_comb begin
    step_result = work_q;
    case (mode_q)
      M_ROR:   step_result = (work_q >> k) | (work_q << k_inv);
      M_ROL:   step_result = (work_q << k) | (work_q >> k_inv);
      M_SHR:   step_result = work_q >> k;
      M_SHL:   step_result = work_q << k;
      M_SHRA:  step_result = $signed(work_q) >>> k;
      default: step_result = work_q;
    endcase
  end

  // Pass-through modes carry no distance so they go straight to DONE.
  always_comb begin
    accept_amount = (in_mode > 3'd4) ? '0 : in_amount;
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    remaining_d = remaining_q;
    mode_d      = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d      = in_data;
          mode_d      = in_mode;
          remaining_d = accept_amount;
          state_d     = (accept_amount != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        work_d      = step_result;
        remaining_d = remaining_q - k;
        if (remaining_q == k) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      work_q      <= '0;
      remaining_q <= '0;
      mode_q      <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      remaining_q <= remaining_d;
      mode_q      <= mode_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    out_data  = work_q;
    out_zero  = ~|work_q;
  end

endmodule

// File: tb/tb_shift_engine.sv
// Directed-vector and reference-model bench for shift_engine at WIDTH=32 with
// four instances using STEP = 1, 4, 2 and 8.
`timescale 1ns/1ps

module tb_shift_engine;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] in_data;
  logic [4:0]  in_amount;
  logic [2:0]  in_mode;
  logic        iv   [4];
  logic        ordy [4];
  logic        ir   [4];
  logic        ov   [4];
  logic        oz   [4];
  logic [31:0] od   [4];

  int checks = 0;
  int errors = 0;
  int steps [4] = '{1, 4, 2, 8};

  always #5 clock = ~clock;

  shift_engine #(.WIDTH(32), .STEP(1)) u_s1 (
    .clock(clock), .clear(clear), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_zero(oz[0]));

  shift_engine #(.WIDTH(32), .STEP(4)) u_s4 (
    .clock(clock), .clear(clear), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_zero(oz[1]));

  shift_engine #(.WIDTH(32), .STEP(2)) u_s2 (
    .clock(clock), .clear(clear), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]), .out_zero(oz[2]));

  shift_engine #(.WIDTH(32), .STEP(8)) u_s8 (
    .clock(clock), .clear(clear), .in_valid(iv[3]), .in_ready(ir[3]),
    .in_data(in_data), .in_amount(in_amount), .in_mode(in_mode),
    .out_valid(ov[3]), .out_ready(ordy[3]), .out_data(od[3]), .out_zero(oz[3]));

  typedef struct {
    int          d;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [2:0]  mode;
    logic [31:0] exp;
    logic        zero;
    int          lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit-index reference: each result bit is picked from its source position.
  function automatic logic [31:0] ref_shift(input logic [31:0] data, input int a, input int mode);
    logic [31:0] r;
    r = data;
    if (mode <= 4) begin
      for (int i = 0; i < 32; i++) begin
        case (mode)
          0: r[i] = data[(i + a) % 32];
          1: r[i] = data[(i - a + 32) % 32];
          2: r[i] = (i + a < 32) ? data[i + a] : 1'b0;
          3: r[i] = (i >= a) ? data[i - a] : 1'b0;
          default: r[i] = (i + a < 32) ? data[i + a] : data[31];
        endcase
      end
    end
    return r;
  endfunction

  task automatic run_op(input int d, input logic [31:0] data, input logic [4:0] amt,
                        input logic [2:0] mode, input logic [31:0] exp_data,
                        input logic exp_zero, input int exp_lat, input bit early_rdy,
                        input string name);
    int n;
    @(negedge clock);
    chk({name, " in_ready idle"}, 64'(ir[d]), 64'd1);
    in_data   = data;
    in_amount = amt;
    in_mode   = mode;
    iv[d]     = 1'b1;
    ordy[d]   = early_rdy;
    @(posedge clock); #1;
    iv[d]     = 1'b0;
    in_data   = $urandom;
    in_amount = 5'($urandom);
    in_mode   = 3'($urandom);
    n = 1;
    while (!ov[d] && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'(exp_lat));
    chk({name, " out_data"}, 64'(od[d]), 64'(exp_data));
    chk({name, " out_zero"}, 64'(oz[d]), 64'(exp_zero));
    ordy[d] = 1'b1;
    @(posedge clock); #1;
    ordy[d] = 1'b0;
    chk({name, " out_valid after handoff"}, 64'(ov[d]), 64'd0);
    chk({name, " in_ready after handoff"}, 64'(ir[d]), 64'd1);
  endtask

  initial begin
    int n;
    int vcount;

    vecs[0]  = '{0, 32'h00000001, 5'd1,  3'd0, 32'h80000000, 1'b0, 2};
    vecs[1]  = '{0, 32'h00000001, 5'd4,  3'd0, 32'h10000000, 1'b0, 5};
    vecs[2]  = '{0, 32'h0000000F, 5'd8,  3'd1, 32'h00000F00, 1'b0, 9};
    vecs[3]  = '{0, 32'hFFFFFFFF, 5'd31, 3'd3, 32'h80000000, 1'b0, 32};
    vecs[4]  = '{0, 32'h80000000, 5'd31, 3'd2, 32'h00000001, 1'b0, 32};
    vecs[5]  = '{0, 32'h80000000, 5'd4,  3'd4, 32'hF8000000, 1'b0, 5};
    vecs[6]  = '{0, 32'h12345678, 5'd0,  3'd0, 32'h12345678, 1'b0, 1};
    vecs[7]  = '{0, 32'h12345678, 5'd5,  3'd6, 32'h12345678, 1'b0, 1};
    vecs[8]  = '{0, 32'h00000001, 5'd1,  3'd2, 32'h00000000, 1'b1, 2};
    vecs[9]  = '{1, 32'hA5A5A5A5, 5'd13, 3'd0, 32'h2D2D2D2D, 1'b0, 5};
    vecs[10] = '{1, 32'h80000000, 5'd31, 3'd4, 32'hFFFFFFFF, 1'b0, 9};
    vecs[11] = '{1, 32'h00000001, 5'd31, 3'd3, 32'h80000000, 1'b0, 9};
    vecs[12] = '{3, 32'h12345678, 5'd12, 3'd1, 32'h45678123, 1'b0, 3};
    vecs[13] = '{2, 32'hFFFFFFFF, 5'd7,  3'd2, 32'h01FFFFFF, 1'b0, 5};

    for (int i = 0; i < 4; i++) begin
      iv[i]   = 1'b0;
      ordy[i] = 1'b0;
    end
    in_data   = '0;
    in_amount = '0;
    in_mode   = '0;
    clear     = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("reset in_ready", 64'(ir[i]), 64'd1);
      chk("reset out_valid", 64'(ov[i]), 64'd0);
      chk("reset out_data", 64'(od[i]), 64'd0);
      chk("reset out_zero", 64'(oz[i]), 64'd1);
    end
    @(negedge clock);
    clear = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].d, vecs[i].data, vecs[i].amt, vecs[i].mode, vecs[i].exp,
             vecs[i].zero, vecs[i].lat, bit'(i % 2), $sformatf("vec%0d", i));
    end

    for (int d = 0; d < 4; d++) begin
      for (int j = 0; j < 30; j++) begin
        logic [31:0] rd;
        logic [31:0] re;
        int ra;
        int rm;
        int rl;
        rd = $urandom;
        ra = int'($urandom_range(0, 31));
        rm = int'($urandom_range(0, 7));
        re = ref_shift(rd, ra, rm);
        rl = (rm > 4) ? 1 : (ra + steps[d] - 1) / steps[d] + 1;
        run_op(d, rd, 5'(ra), 3'(rm), re, (re == 32'h0), rl, bit'(j % 2),
               $sformatf("rand s%0d m%0d a%0d", steps[d], rm, ra));
      end
    end

    // Result held in DONE while the requester keeps in_valid high with new operands.
    @(negedge clock);
    in_data = 32'h00000003; in_amount = 5'd2; in_mode = 3'd3; iv[0] = 1'b1;
    @(posedge clock); #1;
    in_data = 32'h00000001; in_amount = 5'd1; in_mode = 3'd0;
    n = 1;
    while (!ov[0] && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("hold latency", 64'(n), 64'd3);
    for (int c = 0; c < 5; c++) begin
      chk("hold out_data", 64'(od[0]), 64'h0000000C);
      chk("hold out_valid", 64'(ov[0]), 64'd1);
      chk("hold in_ready", 64'(ir[0]), 64'd0);
      @(posedge clock); #1;
    end
    ordy[0] = 1'b1;
    @(posedge clock); #1;
    ordy[0] = 1'b0;
    chk("handoff no accept out_valid", 64'(ov[0]), 64'd0);
    chk("handoff no accept in_ready", 64'(ir[0]), 64'd1);
    @(posedge clock); #1;
    iv[0] = 1'b0;
    chk("held request accepted", 64'(ir[0]), 64'd0);
    n = 1;
    while (!ov[0] && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("held request latency", 64'(n), 64'd2);
    chk("held request out_data", 64'(od[0]), 64'h80000000);
    ordy[0] = 1'b1;
    @(posedge clock); #1;
    ordy[0] = 1'b0;

    // clear in the middle of RUN discards the operation.
    @(negedge clock);
    in_data = 32'h00000001; in_amount = 5'd20; in_mode = 3'd3; iv[0] = 1'b1;
    @(posedge clock); #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clear run in_ready", 64'(ir[0]), 64'd1);
    chk("clear run out_valid", 64'(ov[0]), 64'd0);
    chk("clear run out_data", 64'(od[0]), 64'd0);
    chk("clear run out_zero", 64'(oz[0]), 64'd1);
    vcount = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clock); #1;
      if (ov[0]) vcount++;
    end
    chk("clear run no out_valid pulse", 64'(vcount), 64'd0);
    run_op(0, 32'h00000001, 5'd20, 3'd3, 32'h00100000, 1'b0, 21, 1'b0, "after clear");

    // clear wins over a simultaneous accept.
    @(negedge clock);
    clear = 1'b1;
    in_data = 32'h000000FF; in_amount = 5'd0; in_mode = 3'd0; iv[1] = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    iv[1] = 1'b0;
    chk("clear vs accept in_ready", 64'(ir[1]), 64'd1);
    chk("clear vs accept out_valid", 64'(ov[1]), 64'd0);
    chk("clear vs accept out_data", 64'(od[1]), 64'd0);

    // clear while waiting in DONE.
    @(negedge clock);
    in_data = 32'h0000ABCD; in_amount = 5'd0; in_mode = 3'd5; iv[2] = 1'b1;
    @(posedge clock); #1;
    iv[2] = 1'b0;
    chk("done before clear out_valid", 64'(ov[2]), 64'd1);
    chk("done before clear out_data", 64'(od[2]), 64'h0000ABCD);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("clear done out_valid", 64'(ov[2]), 64'd0);
    chk("clear done out_data", 64'(od[2]), 64'd0);
    chk("clear done in_ready", 64'(ir[2]), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
